// File: rtl/drive_strength_resolver_if.sv
// rtl/drive_strength_resolver_if.sv - Driver inputs and resolved-bus outputs of drive_strength_resolver
// Purpose: bundles the per-driver inputs and the per-bit resolved bus state.
// Signals:
//   drv_en       [N_DRV]        driver i enabled when bit i is set
//   drv_val      [N_DRV*WIDTH]  driver i value in slice [i*WIDTH +: WIDTH]
//   drv_s0       [N_DRV*3]      driver i strength when driving 0
//   drv_s1       [N_DRV*3]      driver i strength when driving 1
//   clr_stats    [1]            clear conflict_cnt
//   bus_val      [WIDTH]        resolved value, 0 where not known
//   bus_known    [WIDTH]        bit is a definite 0/1 (driven or held)
//   bus_z        [WIDTH]        bit is floating
//   bus_held     [WIDTH]        bit value comes from the keeper
//   bus_conflict [WIDTH]        bit is in contention
//   conflict_cnt [CNT_W]        saturating count of cycles with any conflict
// Modports: master drives the driver inputs, slave is the resolver.
interface drive_strength_resolver_if #(
   parameter int N_DRV = 4,
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic [N_DRV-1:0]       drv_en;
   logic [N_DRV*WIDTH-1:0] drv_val;
   logic [N_DRV*3-1:0]     drv_s0;
   logic [N_DRV*3-1:0]     drv_s1;
   logic                   clr_stats;
   logic [WIDTH-1:0]       bus_val;
   logic [WIDTH-1:0]       bus_known;
   logic [WIDTH-1:0]       bus_z;
   logic [WIDTH-1:0]       bus_held;
   logic [WIDTH-1:0]       bus_conflict;
   logic [CNT_W-1:0]       conflict_cnt;

   modport master (
      output drv_en, drv_val, drv_s0, drv_s1, clr_stats,
      input  bus_val, bus_known, bus_z, bus_held, bus_conflict, conflict_cnt
   );

   modport slave (
      input  drv_en, drv_val, drv_s0, drv_s1, clr_stats,
      output bus_val, bus_known, bus_z, bus_held, bus_conflict, conflict_cnt
   );
endinterface

// File: rtl/drive_strength_resolver.sv
// rtl/drive_strength_resolver.sv - Strongest-wins multi-driver bus resolver with keeper and conflict counter
// Purpose: resolves N_DRV strength-coded drivers onto a WIDTH-bit bus, one
// registered state machine per bit (DRIVEN/HOLD/FLOAT/CONFLICT), plus a
// saturating count of cycles in which any bit was in contention.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - synchronous active-low reset, every bit to FLOAT, counter to 0
//   bus_if  - slave modport of drive_strength_resolver_if (driver inputs,
//             clr_stats, resolved bus outputs and conflict_cnt)
module drive_strength_resolver #(
   parameter int N_DRV       = 4,
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   drive_strength_resolver_if.slave    bus_if
);
   // Hold counter must be at least one bit wide even when the keeper is off.
   localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT =
      (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_DRV0 = 2'd1;
   localparam logic [1:0] RES_DRV1 = 2'd2;
   localparam logic [1:0] RES_X    = 2'd3;

   typedef enum logic [1:0] {
      ST_DRIVEN   = 2'd0,
      ST_HOLD     = 2'd1,
      ST_FLOAT    = 2'd2,
      ST_CONFLICT = 2'd3
   } state_t;

   // Codes above supply (5..7) behave as supply.
   function automatic logic [2:0] clamp_s(input logic [2:0] s);
      return (s > 3'd4) ? 3'd4 : s;
   endfunction

   logic [2:0]        w_m0  [WIDTH];
   logic [2:0]        w_m1  [WIDTH];
   logic [1:0]        w_res [WIDTH];
   logic              w_any_x;

   state_t            r_state [WIDTH];
   logic [HOLD_W-1:0] r_hold  [WIDTH];
   logic [WIDTH-1:0]  r_store;
   logic [WIDTH-1:0]  r_val;
   logic [WIDTH-1:0]  r_known;
   logic [WIDTH-1:0]  r_z;
   logic [WIDTH-1:0]  r_held;
   logic [WIDTH-1:0]  r_conf;
   logic [CNT_W-1:0]  r_cnt;

   // Per bit: strongest 1-driver against strongest 0-driver.
   always_comb begin
      w_any_x = 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
         w_m0[b] = 3'd0;
         w_m1[b] = 3'd0;
         for (int i = 0; i < N_DRV; i++) begin
            if (bus_if.drv_en[i]) begin
               if (bus_if.drv_val[i*WIDTH + b]) begin
                  if (clamp_s(bus_if.drv_s1[i*3 +: 3]) > w_m1[b])
                     w_m1[b] = clamp_s(bus_if.drv_s1[i*3 +: 3]);
               end else begin
                  if (clamp_s(bus_if.drv_s0[i*3 +: 3]) > w_m0[b])
                     w_m0[b] = clamp_s(bus_if.drv_s0[i*3 +: 3]);
               end
            end
         end
         if (w_m1[b] > w_m0[b])
            w_res[b] = RES_DRV1;
         else if (w_m0[b] > w_m1[b])
            w_res[b] = RES_DRV0;
         else if (w_m1[b] == 3'd0)
            w_res[b] = RES_NONE;
         else
            w_res[b] = RES_X;
         if (w_res[b] == RES_X)
            w_any_x = 1'b1;
      end
   end

   // Per-bit state machines with registered outputs, plus the conflict counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < WIDTH; b++) begin
            r_state[b] <= ST_FLOAT;
            r_hold[b]  <= '0;
         end
         r_store <= '0;
         r_val   <= '0;
         r_known <= '0;
         r_z     <= '1;
         r_held  <= '0;
         r_conf  <= '0;
         r_cnt   <= '0;
      end else begin
         for (int b = 0; b < WIDTH; b++) begin
            case (w_res[b])
               RES_DRV0, RES_DRV1: begin
                  r_state[b] <= ST_DRIVEN;
                  r_store[b] <= (w_res[b] == RES_DRV1);
                  r_val[b]   <= (w_res[b] == RES_DRV1);
                  r_known[b] <= 1'b1;
                  r_z[b]     <= 1'b0;
                  r_held[b]  <= 1'b0;
                  r_conf[b]  <= 1'b0;
               end
               RES_X: begin
                  r_state[b] <= ST_CONFLICT;
                  r_val[b]   <= 1'b0;
                  r_known[b] <= 1'b0;
                  r_z[b]     <= 1'b0;
                  r_held[b]  <= 1'b0;
                  r_conf[b]  <= 1'b1;
               end
               default: begin
                  // Undriven: only a previously driven bit gets a keeper.
                  if ((r_state[b] == ST_DRIVEN && HOLD_CYCLES > 0) ||
                      (r_state[b] == ST_HOLD && r_hold[b] != '0)) begin
                     r_state[b] <= ST_HOLD;
                     r_hold[b]  <= (r_state[b] == ST_DRIVEN) ? HOLD_INIT
                                                             : r_hold[b] - HOLD_W'(1);
                     r_val[b]   <= r_store[b];
                     r_known[b] <= 1'b1;
                     r_z[b]     <= 1'b0;
                     r_held[b]  <= 1'b1;
                     r_conf[b]  <= 1'b0;
                  end else begin
                     r_state[b] <= ST_FLOAT;
                     r_val[b]   <= 1'b0;
                     r_known[b] <= 1'b0;
                     r_z[b]     <= 1'b1;
                     r_held[b]  <= 1'b0;
                     r_conf[b]  <= 1'b0;
                  end
               end
            endcase
         end

         // A clear in a conflict cycle counts that cycle.
         if (bus_if.clr_stats)
            r_cnt <= w_any_x ? CNT_W'(1) : '0;
         else if (w_any_x && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus_if.bus_val      = r_val;
   assign bus_if.bus_known    = r_known;
   assign bus_if.bus_z        = r_z;
   assign bus_if.bus_held     = r_held;
   assign bus_if.bus_conflict = r_conf;
   assign bus_if.conflict_cnt = r_cnt;
endmodule

// File: tb/tb_drive_strength_resolver.sv
// tb/tb_drive_strength_resolver.sv - Scoreboard bench for drive_strength_resolver
module tb_drive_strength_resolver;
   typedef struct {
      int         dsel;
      string      name;
      logic [7:0] val;
      logic [7:0] known;
      logic [7:0] z;
      logic [7:0] held;
      logic [7:0] conf;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  t_en  = '0;
   logic [31:0] t_val = '0;
   logic [11:0] t_s0  = '0;
   logic [11:0] t_s1  = '0;
   logic        t_clr = 1'b0;

   always #5 clk = ~clk;

   drive_strength_resolver_if #(.N_DRV(4), .WIDTH(8), .CNT_W(8)) ifa ();
   drive_strength_resolver_if #(.N_DRV(4), .WIDTH(8), .CNT_W(2)) ifb ();
   drive_strength_resolver_if #(.N_DRV(4), .WIDTH(8), .CNT_W(8)) ifc ();

   assign ifa.drv_en = t_en;  assign ifa.drv_val = t_val;
   assign ifa.drv_s0 = t_s0;  assign ifa.drv_s1  = t_s1;  assign ifa.clr_stats = t_clr;
   assign ifb.drv_en = t_en;  assign ifb.drv_val = t_val;
   assign ifb.drv_s0 = t_s0;  assign ifb.drv_s1  = t_s1;  assign ifb.clr_stats = t_clr;
   assign ifc.drv_en = t_en;  assign ifc.drv_val = t_val;
   assign ifc.drv_s0 = t_s0;  assign ifc.drv_s1  = t_s1;  assign ifc.clr_stats = t_clr;

   drive_strength_resolver #(.N_DRV(4), .WIDTH(8), .HOLD_CYCLES(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus_if(ifa));
   drive_strength_resolver #(.N_DRV(4), .WIDTH(8), .HOLD_CYCLES(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus_if(ifb));
   drive_strength_resolver #(.N_DRV(4), .WIDTH(8), .HOLD_CYCLES(0), .CNT_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus_if(ifc));

   task automatic drive(input logic [3:0] en, input logic [31:0] val,
                        input logic [11:0] s0, input logic [11:0] s1, input logic clr);
      t_en = en; t_val = val; t_s0 = s0; t_s1 = s1; t_clr = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected state of DUT dsel (0=a, 1=b, 2=c) after the edge just taken.
   task automatic exp_push(input int dsel, input string name,
                           input logic [7:0] val, input logic [7:0] known,
                           input logic [7:0] z, input logic [7:0] held,
                           input logic [7:0] conf, input logic [7:0] cnt);
      exp_t e;
      e.dsel = dsel; e.name = name; e.val = val; e.known = known;
      e.z = z; e.held = held; e.conf = conf; e.cnt = cnt;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [47:0] act;
      logic [47:0] req;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.dsel)
            0: act = {ifa.bus_val, ifa.bus_known, ifa.bus_z, ifa.bus_held,
                      ifa.bus_conflict, ifa.conflict_cnt};
            1: act = {ifb.bus_val, ifb.bus_known, ifb.bus_z, ifb.bus_held,
                      ifb.bus_conflict, 6'b0, ifb.conflict_cnt};
            default: act = {ifc.bus_val, ifc.bus_known, ifc.bus_z, ifc.bus_held,
                            ifc.bus_conflict, ifc.conflict_cnt};
         endcase
         req = {e.val, e.known, e.z, e.held, e.conf, e.cnt};
         n_checks++;
         if (act !== req) begin
            n_errors++;
            $display("FAIL %s (dut %0d): got val=%h known=%h z=%h held=%h conf=%h cnt=%h, want val=%h known=%h z=%h held=%h conf=%h cnt=%h",
                     e.name, e.dsel, act[47:40], act[39:32], act[31:24], act[23:16],
                     act[15:8], act[7:0], e.val, e.known, e.z, e.held, e.conf, e.cnt);
         end
      end
   end

   initial begin
      // Reset and idle float
      drive(4'b0000, 32'h0, 12'o0, 12'o0, 1'b0);
      rst_n = 1'b0;
      tick(); exp_push(0, "reset",      8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd0);
      rst_n = 1'b1;
      tick(); exp_push(0, "idle_float", 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd0);

      // Supply 0xA5 against pull 0x5A
      drive(4'b0011, 32'h00005AA5, 12'o0024, 12'o0024, 1'b0);
      tick(); exp_push(0, "supply_beats_pull", 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd0);

      // Weak 1 against weak 0 on every bit
      drive(4'b0011, 32'h000000FF, 12'o0010, 12'o0001, 1'b0);
      tick(); exp_push(0, "conflict_1", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd1);
      tick(); exp_push(0, "conflict_2", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd2);
      tick(); exp_push(0, "conflict_3", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd3);
      drive(4'b0011, 32'h000000FF, 12'o0010, 12'o0001, 1'b1);
      tick(); exp_push(0, "clr_with_conflict",   8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd1);
              exp_push(1, "b_clr_with_conflict", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd1);
      drive(4'b0011, 32'h000000FF, 12'o0010, 12'o0001, 1'b0);
      tick(); exp_push(0, "conflict_after_clr", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd2);
      tick();
      tick(); exp_push(1, "b_saturate",  8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd3);
      tick(); exp_push(1, "b_sat_stay",  8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd3);
              exp_push(0, "a_cnt_5",     8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd5);

      // Keeper: drive 0x3C, release, hold four cycles then float
      drive(4'b0001, 32'h0000003C, 12'o0004, 12'o0004, 1'b0);
      tick(); exp_push(0, "drive_3c", 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd5);
      drive(4'b0000, 32'h0, 12'o0, 12'o0, 1'b0);
      tick(); exp_push(0, "held_1",        8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'd5);
              exp_push(2, "c_no_keeper",   8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd5);
      tick(); exp_push(0, "held_2",        8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'd5);
      tick(); exp_push(0, "held_3",        8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'd5);
      tick(); exp_push(0, "held_4",        8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'd5);
      tick(); exp_push(0, "hold_expired",  8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd5);

      // Re-drive during hold cycle 2
      drive(4'b0001, 32'h0000003C, 12'o0004, 12'o0004, 1'b0);
      tick();
      drive(4'b0000, 32'h0, 12'o0, 12'o0, 1'b0);
      tick();
      tick(); exp_push(0, "held_before_redrive", 8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'd5);
      drive(4'b0001, 32'h00000081, 12'o0004, 12'o0004, 1'b0);
      tick(); exp_push(0, "redrive_wins", 8'h81, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd5);

      // Reset in the middle of a hold
      drive(4'b0000, 32'h0, 12'o0, 12'o0, 1'b0);
      tick(); exp_push(0, "held_81", 8'h81, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'd5);
      tick();
      rst_n = 1'b0;
      tick(); exp_push(0, "reset_mid_hold",   8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd0);
              exp_push(1, "b_reset_mid_hold", 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd0);
      rst_n = 1'b1;

      // Code 7 on a 1 against supply on a 0: equal strength
      drive(4'b0011, 32'h000000FF, 12'o0040, 12'o0007, 1'b0);
      tick(); exp_push(0, "code7_vs_supply", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd1);

      // Two agreeing strong drivers against a pull driver
      drive(4'b0111, 32'h00F00F0F, 12'o0233, 12'o0233, 1'b0);
      tick(); exp_push(0, "agree_strong_vs_pull", 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd1);

      // Conflict on the low nibble only
      drive(4'b0011, 32'h0000000F, 12'o0022, 12'o0002, 1'b0);
      tick(); exp_push(0, "partial_conflict", 8'h00, 8'hF0, 8'h00, 8'h00, 8'h0F, 8'd2);

      // Enabled driver with strength 0 resolves to nothing
      drive(4'b0001, 32'h000000FF, 12'o0000, 12'o0000, 1'b0);
      tick(); exp_push(0, "zero_strength",   8'h00, 8'hF0, 8'h0F, 8'hF0, 8'h00, 8'd2);
              exp_push(2, "c_zero_strength", 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd2);

      // Driver 3 code 5 (supply) over driver 0 strong
      drive(4'b1001, 32'h550000AA, 12'o5003, 12'o5003, 1'b0);
      tick(); exp_push(0, "drv3_code5_wins", 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd2);

      drive(4'b0000, 32'h0, 12'o0, 12'o0, 1'b0);
      tick();
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
